// File: rtl/subterranean_stream_arbiter.sv
// Session arbiter in front of a single subterranean_stream core.
// A client holds c_req for a whole session. It is granted round-robin and
// is then wired straight through to the core with zero latency. When the
// client drops its request, the arbiter drains the core in RELEASE until
// the core reports idle.
module subterranean_stream_arbiter #(
  parameter int N_CLIENTS = 2,
  parameter int ID_W      = 3
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic [N_CLIENTS-1:0]    c_req,
  output logic [N_CLIENTS-1:0]    c_gnt,
  input  logic [4*N_CLIENTS-1:0]  c_inst,
  input  logic [N_CLIENTS-1:0]    c_inst_valid,
  output logic [N_CLIENTS-1:0]    c_inst_ready,
  input  logic [32*N_CLIENTS-1:0] c_din,
  input  logic [3*N_CLIENTS-1:0]  c_din_size,
  input  logic [N_CLIENTS-1:0]    c_din_last,
  input  logic [N_CLIENTS-1:0]    c_din_valid,
  output logic [N_CLIENTS-1:0]    c_din_ready,
  output logic [32*N_CLIENTS-1:0] c_dout,
  output logic [3*N_CLIENTS-1:0]  c_dout_size,
  output logic [N_CLIENTS-1:0]    c_dout_last,
  output logic [N_CLIENTS-1:0]    c_dout_valid,
  input  logic [N_CLIENTS-1:0]    c_dout_ready,
  output logic [3:0]              m_inst,
  output logic                    m_inst_valid,
  input  logic                    m_inst_ready,
  output logic [31:0]             m_din,
  output logic [2:0]              m_din_size,
  output logic                    m_din_last,
  output logic                    m_din_valid,
  input  logic                    m_din_ready,
  input  logic [31:0]             m_dout,
  input  logic [2:0]              m_dout_size,
  input  logic                    m_dout_last,
  input  logic                    m_dout_valid,
  output logic                    m_dout_ready,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [N_CLIENTS-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_q, rr_d;

  logic                   req_found;
  logic [ID_W-1:0]        pick;
  logic [ID_W-1:0]        pick_next;
  logic                   owner_req;

  // Round-robin search: the first requester at or after rr_q, wrapping N-1 -> 0.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    req_found = 1'b0;
    pick      = '0;
    pick_next = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (!req_found && c_req[i] &&
            ((int'(rr_q) + k == i) || (int'(rr_q) + k == i + N_CLIENTS))) begin
          req_found = 1'b1;
          pick      = ID_W'(i);
          pick_next = (i == N_CLIENTS - 1) ? '0 : ID_W'(i + 1);
        end
      end
    end
  end

  // Request line of the client that currently owns the session.
  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant_id_q == ID_W'(i)) owner_req = c_req[i];
    end
  end

  // Next-state logic for the session FSM and its registered outputs.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d    = BUSY;
          gnt_d      = {{(N_CLIENTS-1){1'b0}}, 1'b1} << pick;
          grant_id_d = pick;
          rr_d       = pick_next;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end
      end
      RELEASE: begin
        if (m_inst_ready) begin
          state_d    = IDLE;
          grant_id_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        grant_id_d = '0;
      end
    endcase
  end

  // State registers; reset aborts any session in flight together with the core.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only, so arstn is not in the sensitivity list.
    if (!arstn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      grant_id_q <= '0;
      rr_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      grant_id_q <= grant_id_d;
      rr_q       <= rr_d;
    end
  end

  // Zero-latency passthrough between the owning client and the core.
  always_comb begin
    m_inst       = '0;
    m_inst_valid = 1'b0;
    m_din        = '0;
    m_din_size   = '0;
    m_din_last   = 1'b0;
    m_din_valid  = 1'b0;
    m_dout_ready = 1'b0;
    c_inst_ready = '0;
    c_din_ready  = '0;
    c_dout       = '0;
    c_dout_size  = '0;
    c_dout_last  = '0;
    c_dout_valid = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (state_q == BUSY && grant_id_q == ID_W'(i)) begin
        m_inst                = c_inst[i*4 +: 4];
        m_inst_valid          = c_inst_valid[i];
        m_din                 = c_din[i*32 +: 32];
        m_din_size            = c_din_size[i*3 +: 3];
        m_din_last            = c_din_last[i];
        m_din_valid           = c_din_valid[i];
        m_dout_ready          = c_dout_ready[i];
        c_inst_ready[i]       = m_inst_ready;
        c_din_ready[i]        = m_din_ready;
        c_dout[i*32 +: 32]    = m_dout;
        c_dout_size[i*3 +: 3] = m_dout_size;
        c_dout_last[i]        = m_dout_last;
        c_dout_valid[i]       = m_dout_valid;
      end
    end
    // Leftover core output after the session is swallowed, not forwarded.
    if (state_q == RELEASE) m_dout_ready = 1'b1;
  end

  assign c_gnt    = gnt_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_subterranean_stream_arbiter.sv
// Bench for subterranean_stream_arbiter (2 clients). Random payloads every cycle
// are checked against a session-level model that tracks only who owns the core,
// whether the owner has let go, and whose turn is next.
module tb_subterranean_stream_arbiter;
  localparam int N  = 2;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            arstn;
  logic [N-1:0]    c_req;
  logic [N-1:0]    c_gnt;
  logic [4*N-1:0]  c_inst;
  logic [N-1:0]    c_inst_valid, c_inst_ready;
  logic [32*N-1:0] c_din;
  logic [3*N-1:0]  c_din_size;
  logic [N-1:0]    c_din_last, c_din_valid, c_din_ready;
  logic [32*N-1:0] c_dout;
  logic [3*N-1:0]  c_dout_size;
  logic [N-1:0]    c_dout_last, c_dout_valid, c_dout_ready;
  logic [3:0]      m_inst;
  logic            m_inst_valid, m_inst_ready;
  logic [31:0]     m_din;
  logic [2:0]      m_din_size;
  logic            m_din_last, m_din_valid, m_din_ready;
  logic [31:0]     m_dout;
  logic [2:0]      m_dout_size;
  logic            m_dout_last, m_dout_valid, m_dout_ready;
  logic            busy;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;

  subterranean_stream_arbiter #(.N_CLIENTS(N), .ID_W(IW)) dut (
    .clk(clk), .arstn(arstn), .c_req(c_req), .c_gnt(c_gnt),
    .c_inst(c_inst), .c_inst_valid(c_inst_valid), .c_inst_ready(c_inst_ready),
    .c_din(c_din), .c_din_size(c_din_size), .c_din_last(c_din_last),
    .c_din_valid(c_din_valid), .c_din_ready(c_din_ready),
    .c_dout(c_dout), .c_dout_size(c_dout_size), .c_dout_last(c_dout_last),
    .c_dout_valid(c_dout_valid), .c_dout_ready(c_dout_ready),
    .m_inst(m_inst), .m_inst_valid(m_inst_valid), .m_inst_ready(m_inst_ready),
    .m_din(m_din), .m_din_size(m_din_size), .m_din_last(m_din_last),
    .m_din_valid(m_din_valid), .m_din_ready(m_din_ready),
    .m_dout(m_dout), .m_dout_size(m_dout_size), .m_dout_last(m_dout_last),
    .m_dout_valid(m_dout_valid), .m_dout_ready(m_dout_ready),
    .busy(busy), .grant_id(grant_id)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Session-level reference: owner = -1 when nobody holds the core.
  int owner = -1;
  bit letting_go = 1'b0;
  int next_turn = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_payload(input bit force_valid);
    c_inst       = 8'($urandom);
    c_inst_valid = 2'($urandom);
    c_din        = {$urandom, $urandom};
    c_din_size   = 6'($urandom);
    c_din_last   = 2'($urandom);
    c_din_valid  = force_valid ? 2'b11 : 2'($urandom);
    c_dout_ready = 2'($urandom);
    m_din_ready  = 1'($urandom);
    m_dout       = $urandom;
    m_dout_size  = 3'($urandom);
    m_dout_last  = 1'($urandom);
    m_dout_valid = 1'($urandom);
  endtask

  // Compare every DUT output with what the session model says it must be.
  task automatic check_outputs();
    bit              act;
    logic [N-1:0]    e_gnt, e_ir, e_dr, e_dl, e_dv;
    logic [32*N-1:0] e_do, tmp_d;
    logic [3*N-1:0]  e_ds, tmp_s;
    logic [3:0]      e_mi;
    logic [31:0]     e_md;
    logic [2:0]      e_ms;
    logic            e_miv, e_ml, e_mv, e_mdr;
    act   = (owner >= 0) && !letting_go;
    e_gnt = '0; e_ir = '0; e_dr = '0; e_dl = '0; e_dv = '0;
    e_do  = '0; e_ds = '0;
    e_mi  = '0; e_md = '0; e_ms = '0;
    e_miv = 1'b0; e_ml = 1'b0; e_mv = 1'b0;
    e_mdr = letting_go;
    if (act) begin
      e_gnt = N'(1) << owner;
      e_mi  = 4'(c_inst >> (4 * owner));
      e_miv = 1'(c_inst_valid >> owner);
      e_md  = 32'(c_din >> (32 * owner));
      e_ms  = 3'(c_din_size >> (3 * owner));
      e_ml  = 1'(c_din_last >> owner);
      e_mv  = 1'(c_din_valid >> owner);
      e_mdr = 1'(c_dout_ready >> owner);
      e_ir  = N'(m_inst_ready) << owner;
      e_dr  = N'(m_din_ready) << owner;
      e_dl  = N'(m_dout_last) << owner;
      e_dv  = N'(m_dout_valid) << owner;
      tmp_d = '0; tmp_d[31:0] = m_dout;
      e_do  = tmp_d << (32 * owner);
      tmp_s = '0; tmp_s[2:0] = m_dout_size;
      e_ds  = tmp_s << (3 * owner);
    end
    check("c_gnt",        96'(c_gnt),        96'(e_gnt));
    check("busy",         96'(busy),         96'(owner >= 0));
    check("grant_id",     96'(grant_id),     96'((owner >= 0) ? owner : 0));
    check("m_inst",       96'(m_inst),       96'(e_mi));
    check("m_inst_valid", 96'(m_inst_valid), 96'(e_miv));
    check("m_din",        96'(m_din),        96'(e_md));
    check("m_din_size",   96'(m_din_size),   96'(e_ms));
    check("m_din_last",   96'(m_din_last),   96'(e_ml));
    check("m_din_valid",  96'(m_din_valid),  96'(e_mv));
    check("m_dout_ready", 96'(m_dout_ready), 96'(e_mdr));
    check("c_inst_ready", 96'(c_inst_ready), 96'(e_ir));
    check("c_din_ready",  96'(c_din_ready),  96'(e_dr));
    check("c_dout",       96'(c_dout),       96'(e_do));
    check("c_dout_size",  96'(c_dout_size),  96'(e_ds));
    check("c_dout_last",  96'(c_dout_last),  96'(e_dl));
    check("c_dout_valid", 96'(c_dout_valid), 96'(e_dv));
  endtask

  // Advance the session model by one clock edge.
  task automatic model_step(input logic [N-1:0] req, input logic rstn, input logic mir);
    if (!rstn) begin
      owner = -1; letting_go = 1'b0; next_turn = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (next_turn + k) % N;
        if (owner < 0 && req[j]) begin
          owner = j;
          next_turn = (j + 1) % N;
        end
      end
    end else if (!letting_go) begin
      if (!req[owner]) letting_go = 1'b1;
    end else if (mir) begin
      owner = -1; letting_go = 1'b0;
    end
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic rstn, input logic mir,
                       input bit force_valid = 1'b0);
    @(negedge clk);
    c_req = req; arstn = rstn; m_inst_ready = mir;
    randomize_payload(force_valid);
    #1 check_outputs();
    @(posedge clk);
    model_step(req, rstn, mir);
  endtask

  initial begin
    logic [N-1:0] rreq;
    arstn = 1'b0; c_req = '0; m_inst_ready = 1'b1;
    randomize_payload(1'b0);

    // Reset, then idle with no requests.
    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 1'b1);

    // Single session from client 0, then release.
    repeat (12) cycle(2'b01, 1'b1, 1'b1);
    check("grant_client0", 96'(c_gnt), 96'(2'b01));
    repeat (3) cycle(2'b00, 1'b1, 1'b1);

    // Tie: client 1 is next in turn after client 0's session.
    repeat (4) cycle(2'b11, 1'b1, 1'b1);
    repeat (6) cycle(2'b10, 1'b1, 1'b1);
    check("grant_client1", 96'(c_gnt), 96'(2'b10));
    repeat (3) cycle(2'b00, 1'b1, 1'b1);
    repeat (4) cycle(2'b11, 1'b1, 1'b1);
    check("tie_alternates", 96'(c_gnt), 96'(2'b01));

    // Client 0 lets go while the core is still working for 5 cycles.
    repeat (5) cycle(2'b10, 1'b1, 1'b0);
    check("release_held", 96'(busy), 96'(1));
    repeat (4) cycle(2'b10, 1'b1, 1'b1);
    repeat (2) cycle(2'b00, 1'b1, 1'b1);

    // Reset in the middle of a session with din valid, client 1 waiting.
    repeat (3) cycle(2'b01, 1'b1, 1'b1, 1'b1);
    cycle(2'b10, 1'b0, 1'b1, 1'b1);
    repeat (4) cycle(2'b10, 1'b1, 1'b1, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 1'b1);

    // Random sessions, core stalls and occasional resets.
    rreq = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) rreq = N'($urandom);
      cycle(rreq, 1'($urandom_range(0, 79) != 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
